// File: rtl/lcd_power_seq.sv
// LCD panel power/clock sequencer: PLL reset and lock qualification, pixel reset
// release, DISP and backlight ordering, orderly shutdown and lock-failure handling.
module lcd_power_seq #(
    parameter int unsigned PLL_RST_CYCLES = 100,
    parameter int unsigned LOCK_TIMEOUT   = 100000,
    parameter int unsigned SETTLE_CYCLES  = 10000,
    parameter int unsigned DISP_DELAY     = 2000000,
    parameter int unsigned BL_DELAY       = 10000000,
    parameter int unsigned OFF_DELAY      = 5000000,
    parameter int unsigned MAX_ATTEMPTS   = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic pll_locked,
    output logic pll_resetb,
    output logic pixel_reset,
    output logic lcd_disp,
    output logic backlight_en,
    output logic ready,
    output logic fault
);

    typedef enum logic [3:0] {
        OFF, PLL_RST, WAIT_LOCK, SETTLE, PIX_START,
        DISP_WAIT, RUN, BL_OFF, DISP_OFF, FAULT
    } state_t;

    localparam logic [23:0] PLL_RST_LAST = 24'(PLL_RST_CYCLES - 1);
    localparam logic [23:0] LOCK_LAST    = 24'(LOCK_TIMEOUT - 1);
    localparam logic [23:0] SETTLE_LAST  = 24'(SETTLE_CYCLES - 1);
    localparam logic [23:0] DISP_LAST    = 24'(DISP_DELAY - 1);
    localparam logic [23:0] BL_LAST      = 24'(BL_DELAY - 1);
    localparam logic [23:0] OFF_LAST     = 24'(OFF_DELAY - 1);
    localparam logic [2:0]  ATT_MAX      = 3'(MAX_ATTEMPTS);

    state_t      state_q, state_d;
    logic [1:0]  sync_q, sync_d;
    logic [23:0] cnt_q, cnt_d;
    logic [2:0]  attempts_q, attempts_d;
    logic [5:0]  out_q, out_d;

    logic        locked_s;
    logic [2:0]  att_inc;
    state_t      fail_state;

    assign locked_s   = sync_q[1];
    assign att_inc    = attempts_q + 3'd1;
    assign fail_state = (att_inc == ATT_MAX) ? FAULT : PLL_RST;

    assign {pll_resetb, pixel_reset, lcd_disp, backlight_en, ready, fault} = out_q;

    always_comb begin
        sync_d     = {sync_q[0], pll_locked};
        state_d    = state_q;
        attempts_d = attempts_q;

        // Lock loss is tested before enable so it wins when both occur together.
        unique case (state_q)
            OFF:       if (enable) state_d = PLL_RST;
            PLL_RST: begin
                if (!enable)                    state_d = OFF;
                else if (cnt_q == PLL_RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (!enable)                 state_d = OFF;
                else if (locked_s)           state_d = SETTLE;
                else if (cnt_q == LOCK_LAST) begin
                    attempts_d = att_inc;
                    state_d    = fail_state;
                end
            end
            SETTLE: begin
                if (!locked_s) begin
                    attempts_d = att_inc;
                    state_d    = fail_state;
                end
                else if (!enable)              state_d = OFF;
                else if (cnt_q == SETTLE_LAST) state_d = PIX_START;
            end
            PIX_START: begin
                if (!locked_s) begin
                    attempts_d = att_inc;
                    state_d    = fail_state;
                end
                else if (!enable)            state_d = OFF;
                else if (cnt_q == DISP_LAST) state_d = DISP_WAIT;
            end
            DISP_WAIT: begin
                if (!locked_s) begin
                    attempts_d = att_inc;
                    state_d    = fail_state;
                end
                else if (!enable)          state_d = BL_OFF;
                else if (cnt_q == BL_LAST) state_d = RUN;
            end
            RUN: begin
                if (!locked_s) begin
                    attempts_d = att_inc;
                    state_d    = fail_state;
                end
                else if (!enable) state_d = BL_OFF;
            end
            BL_OFF:   if (cnt_q == OFF_LAST) state_d = DISP_OFF;
            DISP_OFF: if (cnt_q == OFF_LAST) state_d = OFF;
            FAULT:    if (!enable) state_d = OFF;
            default:  state_d = OFF;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
            if (state_d == OFF || state_d == RUN) attempts_d = '0;
        end else begin
            cnt_d = cnt_q + 24'd1;
        end

        // {pll_resetb, pixel_reset, lcd_disp, backlight_en, ready, fault}
        unique case (state_d)
            WAIT_LOCK, SETTLE:  out_d = 6'b110000;
            PIX_START:          out_d = 6'b100000;
            DISP_WAIT, BL_OFF:  out_d = 6'b101000;
            RUN:                out_d = 6'b101110;
            DISP_OFF:           out_d = 6'b100000;
            FAULT:              out_d = 6'b010001;
            default:            out_d = 6'b010000;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= OFF;
            sync_q     <= '0;
            cnt_q      <= '0;
            attempts_q <= '0;
            out_q      <= 6'b010000;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            attempts_q <= attempts_d;
            out_q      <= out_d;
        end
    end

endmodule

// File: tb/tb_lcd_power_seq.sv
// Directed bench for lcd_power_seq with short timing parameters; expected output
// vectors {pll_resetb, pixel_reset, lcd_disp, backlight_en, ready, fault} are hand-derived.
module tb_lcd_power_seq;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic pll_locked = 1'b1;
    logic pll_resetb, pixel_reset, lcd_disp, backlight_en, ready, fault;
    logic [5:0] obs;

    int tests = 0;
    int fails = 0;

    localparam logic [5:0] V_OFF   = 6'b010000;
    localparam logic [5:0] V_WAIT  = 6'b110000;
    localparam logic [5:0] V_PIX   = 6'b100000;
    localparam logic [5:0] V_DISP  = 6'b101000;
    localparam logic [5:0] V_RUN   = 6'b101110;
    localparam logic [5:0] V_FAULT = 6'b010001;

    lcd_power_seq #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT(20),
        .SETTLE_CYCLES(8),
        .DISP_DELAY(10),
        .BL_DELAY(6),
        .OFF_DELAY(5),
        .MAX_ATTEMPTS(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .pll_locked(pll_locked),
        .pll_resetb(pll_resetb),
        .pixel_reset(pixel_reset),
        .lcd_disp(lcd_disp),
        .backlight_en(backlight_en),
        .ready(ready),
        .fault(fault)
    );

    always #5 clock = ~clock;

    assign obs = {pll_resetb, pixel_reset, lcd_disp, backlight_en, ready, fault};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic hold(input string tag, input int n, input logic [5:0] exp);
        for (int i = 0; i < n; i++) begin
            tick();
            check(tag, 32'(obs), 32'(exp));
        end
    endtask

    // Call just after enable=1 is driven with lock already (or about to be) high.
    task automatic powerup(input string pfx);
        hold({pfx, "_pll_rst"}, 4, V_OFF);
        hold({pfx, "_wait_lock"}, 1, V_WAIT);
        hold({pfx, "_settle"}, 8, V_WAIT);
        hold({pfx, "_pix_start"}, 10, V_PIX);
        hold({pfx, "_disp_wait"}, 6, V_DISP);
        hold({pfx, "_run"}, 3, V_RUN);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("reset_outputs", 32'(obs), 32'(V_OFF));
        check("reset_attempts", 32'(dut.attempts_q), 32'd0);
        reset = 1'b0;
        hold("idle_off", 3, V_OFF);

        // Power-up with lock tied high
        enable = 1'b1;
        powerup("up");

        // Orderly shutdown from RUN
        enable = 1'b0;
        hold("bl_off", 5, V_DISP);
        hold("disp_off", 5, V_PIX);
        hold("off_after_shutdown", 2, V_OFF);

        // Lock never arrives: three attempts then FAULT
        pll_locked = 1'b0;
        hold("off_nolock", 3, V_OFF);
        enable = 1'b1;
        for (int a = 0; a < 3; a++) begin
            hold("fl_pll_rst", 4, V_OFF);
            hold("fl_wait_lock", 20, V_WAIT);
        end
        hold("fault", 3, V_FAULT);
        check("fault_attempts", 32'(dut.attempts_q), 32'd3);
        enable = 1'b0;
        tick();
        check("fault_exit", 32'(obs), 32'(V_OFF));
        check("fault_exit_attempts", 32'(dut.attempts_q), 32'd0);

        // One-cycle lock glitch during SETTLE
        pll_locked = 1'b1;
        enable = 1'b1;
        hold("g_pll_rst", 4, V_OFF);
        hold("g_wait_lock", 1, V_WAIT);
        hold("g_settle", 3, V_WAIT);
        pll_locked = 1'b0;
        tick();
        check("g_settle_sync1", 32'(obs), 32'(V_WAIT));
        pll_locked = 1'b1;
        tick();
        check("g_settle_sync2", 32'(obs), 32'(V_WAIT));
        check("g_attempts_before", 32'(dut.attempts_q), 32'd0);
        powerup("g");
        check("g_run_attempts", 32'(dut.attempts_q), 32'd0);

        // Lock loss in RUN with enable dropping on the same decision edge
        pll_locked = 1'b0;
        tick();
        check("ll_run_edge1", 32'(obs), 32'(V_RUN));
        tick();
        check("ll_run_edge2", 32'(obs), 32'(V_RUN));
        enable = 1'b0;
        tick();
        check("ll_edge3_outputs", 32'(obs), 32'(V_OFF));
        check("ll_edge3_attempts", 32'(dut.attempts_q), 32'd1);
        tick();
        check("ll_to_off_outputs", 32'(obs), 32'(V_OFF));
        check("ll_to_off_attempts", 32'(dut.attempts_q), 32'd0);
        hold("ll_off_hold", 6, V_OFF);

        // Asynchronous reset while in DISP_WAIT
        pll_locked = 1'b1;
        enable = 1'b1;
        hold("ar_pll_rst", 4, V_OFF);
        hold("ar_wait_lock", 1, V_WAIT);
        hold("ar_settle", 8, V_WAIT);
        hold("ar_pix_start", 10, V_PIX);
        hold("ar_disp_wait", 2, V_DISP);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", 32'(obs), 32'(V_OFF));
        check("async_reset_attempts", 32'(dut.attempts_q), 32'd0);
        hold("reset_held", 2, V_OFF);
        reset = 1'b0;
        enable = 1'b0;
        hold("post_reset_off", 2, V_OFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
